// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: display stage for a 3-digit packed BCD value. It captures the value on Load,
// then scans the digits units -> tens -> hundreds onto a shared 7-segment bus.
// Each digit slot lasts REFRESH_DIV clocks.
//   Clock    : system clock, rising edge
//   Rst_     : asynchronous active-low reset
//   Load     : 1-cycle capture strobe
//   BcdIn    : [11:8] hundreds, [7:4] tens, [3:0] units
//   Blank_En : 1 = suppress leading zeros
//   Seg      : segments {g,f,e,d,c,b,a}, active-low, registered
//   An       : anodes {hund,tens,units}, active-low one-hot, registered
//   Valid    : a value has been captured since reset
//   Err      : last captured value held a nibble > 9
module bcd_seg_scan #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        Clock,
  input  logic        Rst_,
  input  logic        Load,
  input  logic [11:0] BcdIn,
  input  logic        Blank_En,
  output logic [6:0]  Seg,
  output logic [2:0]  An,
  output logic        Valid,
  output logic        Err
);

  typedef enum logic [1:0] {StIdle, StUnit, StTens, StHund} state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(REFRESH_DIV - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [6:0]       seg_q, seg_d;
  logic [2:0]       an_q, an_d;
  logic             tick;
  logic             hund_blank, tens_blank;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;  // '-' for non-BCD nibble
    endcase
    return s;
  endfunction

  // Refresh counter is parked at 0 while idle so the first slot gets a full period.
  always_comb begin
    tick = (state_q != StIdle) && (cnt_q == CntMax);
    if (state_q == StIdle || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (Load) state_d = StUnit;
      StUnit:  if (tick) state_d = StTens;
      StTens:  if (tick) state_d = StHund;
      StHund:  if (tick) state_d = StUnit;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (Load) begin
      data_d  = BcdIn;
      valid_d = 1'b1;
      err_d   = (BcdIn[11:8] > 4'd9) || (BcdIn[7:4] > 4'd9) || (BcdIn[3:0] > 4'd9);
    end
  end

  // Outputs are built from the next state and next data so a capture shows one edge later.
  always_comb begin
    hund_blank = Blank_En && (data_d[11:8] == 4'd0);
    tens_blank = hund_blank && (data_d[7:4] == 4'd0);
    an_d       = 3'b111;
    seg_d      = 7'h7F;
    unique case (state_d)
      StUnit: begin
        an_d  = 3'b110;
        seg_d = decode(data_d[3:0]);
      end
      StTens: begin
        an_d  = 3'b101;
        seg_d = tens_blank ? 7'h7F : decode(data_d[7:4]);
      end
      StHund: begin
        an_d  = 3'b011;
        seg_d = hund_blank ? 7'h7F : decode(data_d[11:8]);
      end
      default: begin
        an_d  = 3'b111;
        seg_d = 7'h7F;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Rst_) begin
    if (!Rst_) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      seg_q   <= 7'h7F;
      an_q    <= 3'b111;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign Seg   = seg_q;
  assign An    = an_q;
  assign Valid = valid_q;
  assign Err   = err_q;

endmodule
